// File: rtl/barrel_shifter_left_pipe_pkg.sv
// Shared constants and helpers for the pipelined left barrel shifter.
// Shift-mode encodings and an elaboration-time log2.
package barrel_pkg;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ROTATE  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter_left_pipe_if.sv
// Producer/consumer handshake bundle for the left barrel shifter.
// master = producer + consumer side, slave = the shifter itself.
interface barrel_shifter_left_pipe_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int SHW = clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic             in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_rot,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_rot,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/barrel_shifter_left_pipe_shl_stage.sv
// One registered shift-by-K stage with its valid/ready slice,
// plus the 2:1 bit mux used to select shifted vs. unshifted data.
module mux2X1 (
  input  logic in0_i,
  input  logic in1_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? in1_i : in0_i;
endmodule

module shl_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH-1:0]       data_i,
  input  logic [clog2(WIDTH)-1:0] amt_i,
  input  logic                   rot_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [clog2(WIDTH)-1:0] amt_o,
  output logic                   rot_o
);
  localparam int SHW = clog2(WIDTH);
  localparam int B   = clog2(K);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] fill;
  logic [SHW-1:0]   amt_q;
  logic             rot_q;

  // Low bits wrap around on rotate, zero-fill otherwise.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= K) begin : g_hi
      assign fill[i] = data_i[i-K];
    end else begin : g_lo
      assign fill[i] = (rot_i == SHIFT_ROTATE) ?
                       data_i[i-K+WIDTH] : 1'b0;
    end
    mux2X1 u_mux (
      .in0_i (data_i[i]),
      .in1_i (fill[i]),
      .sel_i (amt_i[B]),
      .y_o   (data_d[i])
    );
  end

  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      rot_q   <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_d;
        amt_q  <= amt_i;
        rot_q  <= rot_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign rot_o   = rot_q;

endmodule

// File: rtl/barrel_shifter_left_pipe.sv
// Pipelined left barrel shifter: one stage per amount bit, MSB first,
// logical (zero fill) or rotate, valid/ready on both sides.
module barrel_shifter_left_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  barrel_shifter_left_pipe_if.slave bus
);
  localparam int SHW = clog2(WIDTH);

  logic             v_c   [SHW+1];
  logic             r_c   [SHW+1];
  logic [WIDTH-1:0] d_c   [SHW+1];
  logic [SHW-1:0]   a_c   [SHW+1];
  logic             rot_c [SHW+1];

  assign v_c[0]   = bus.in_valid;
  assign d_c[0]   = bus.in_data;
  assign a_c[0]   = bus.in_amt;
  assign rot_c[0] = bus.in_rot;
  assign r_c[SHW] = bus.out_ready;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    shl_stage #(
      .WIDTH (WIDTH),
      .K     (WIDTH >> (s + 1))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (v_c[s]),
      .ready_o (r_c[s]),
      .data_i  (d_c[s]),
      .amt_i   (a_c[s]),
      .rot_i   (rot_c[s]),
      .valid_o (v_c[s+1]),
      .ready_i (r_c[s+1]),
      .data_o  (d_c[s+1]),
      .amt_o   (a_c[s+1]),
      .rot_o   (rot_c[s+1])
    );
  end

  assign bus.in_ready  = r_c[0];
  assign bus.out_valid = v_c[SHW];
  assign bus.out_data  = d_c[SHW];

endmodule

// File: tb/tb_barrel_shifter_left_pipe.sv
// Scoreboard bench for barrel_shifter_left_pipe: directed beats,
// streaming, backpressure and mid-stream reset.
module tb_barrel_shifter_left_pipe;
  import barrel_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    int           acc;
    bit           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrel_shifter_left_pipe_if #(.WIDTH(W)) bif ();

  barrel_shifter_left_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  exp_t         sb[$];
  exp_t         e;
  int           compared   = 0;
  int           mismatched = 0;
  int           cyc        = 0;
  logic [W-1:0] exp_cur    = '0;
  bit           lat_cur    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [W-1:0] ref_shl(input logic [W-1:0] d,
                                            input logic [2:0] a,
                                            input logic r);
    logic [2*W-1:0] t;
    if (r == SHIFT_ROTATE) begin
      t = {d, d} << a;
      return t[2*W-1:W];
    end
    t = {{W{1'b0}}, d} << a;
    return t[W-1:0];
  endfunction

  // Input side: record the expected result of every accepted beat.
  always @(negedge clk) begin
    if (!rst && bif.in_valid && bif.in_ready)
      sb.push_back('{exp_cur, cyc, lat_cur});
  end

  // Output side: every transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_out: got %0h want none", bif.out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", {24'h0, bif.out_data}, {24'h0, e.d});
        if (e.lat) chk("latency", cyc - e.acc, 3);
      end
    end
  end

  task automatic drive(input logic [W-1:0] d, input logic [2:0] a,
                       input logic r, input logic [W-1:0] x,
                       input bit lat);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    bif.in_amt   = a;
    bif.in_rot   = r;
    exp_cur      = x;
    lat_cur      = lat;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [2:0] a,
                      input logic r, input logic [W-1:0] x);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive(d, a, r, x, 1'b1);
    do begin
      @(negedge clk);
      n++;
    end while (!bif.in_ready && n < 20);
    chk("accept", {31'h0, bif.in_ready}, 1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_left", sb.size(), 0);
  endtask

  logic [W-1:0] bp_d [6] = '{8'h11, 8'h22, 8'hC3, 8'h44, 8'h55, 8'h66};
  logic [2:0]   bp_a [6] = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
  logic         bp_r [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [W-1:0] bp_e [6] = '{8'h22, 8'h88, 8'h3C, 8'h44, 8'h55, 8'h66};

  initial begin
    int acc;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.in_amt    = '0;
    bif.in_rot    = 1'b0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, bif.out_valid}, 0);
    chk("rst_in_ready", {31'h0, bif.in_ready}, 1);
    chk("rst_out_data", {24'h0, bif.out_data}, 0);

    send(8'hB3, 3'd3, 1'b0, 8'h98);
    drain();
    send(8'hB3, 3'd3, 1'b1, 8'h9D);
    send(8'h81, 3'd1, 1'b1, 8'h03);
    send(8'hFF, 3'd7, 1'b0, 8'h80);
    send(8'h5A, 3'd0, 1'b0, 8'h5A);
    send(8'h5A, 3'd0, 1'b1, 8'h5A);
    send(8'h01, 3'd7, 1'b1, 8'h80);
    drain();

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] d;
      logic [2:0]   a;
      logic         r;
      d = W'(i);
      a = 3'(i % 8);
      r = d[3];
      @(posedge clk); #1;
      drive(d, a, r, ref_shl(d, a, r), 1'b1);
      @(negedge clk);
      chk("stream_in_ready", {31'h0, bif.in_ready}, 1);
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    drain();

    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(bp_d[acc], bp_a[acc], bp_r[acc], bp_e[acc], 1'b0);
      @(negedge clk);
      if (bif.in_valid && bif.in_ready) acc++;
      if (c >= 3) begin
        chk("bp_out_valid", {31'h0, bif.out_valid}, 1);
        chk("bp_hold", {24'h0, bif.out_data}, 32'h22);
      end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready_low", {31'h0, bif.in_ready}, 0);
    @(posedge clk); #1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    drain();

    @(posedge clk); #1;
    drive(8'h0F, 3'd1, 1'b0, 8'h1E, 1'b1);
    @(posedge clk); #1;
    drive(8'hF0, 3'd2, 1'b1, 8'hC3, 1'b1);
    @(posedge clk); #1;
    drive(8'h3C, 3'd3, 1'b0, 8'hE0, 1'b1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'h0, bif.out_valid}, 0);
    chk("mid_rst_in_ready", {31'h0, bif.in_ready}, 1);
    repeat (8) @(negedge clk);
    send(8'h81, 3'd7, 1'b0, 8'h80);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
